// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered SAP ALU with shift-add multiply and tri-state result bus
// Non-MUL ops complete at the start edge; MUL iterates one multiplier bit per cycle.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic [2:0]       su,
  input  logic             start,
  input  logic             eu,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             busy,
  output logic             done,
  output logic [3:0]       flags
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   result_q;
  logic [3:0]         flags_q;
  logic               done_q;

  logic               accept;
  logic               mul_last;
  logic [WIDTH:0]     add_w;
  logic [WIDTH:0]     sub_w;
  logic [WIDTH-1:0]   alu_val;
  logic               alu_c;
  logic               alu_v;
  logic [2*WIDTH-1:0] partial;
  logic [2*WIDTH-1:0] prod_next;
  logic               load_en;
  logic [WIDTH-1:0]   load_val;
  logic               load_c;
  logic               load_v;

  // State register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && su == OP_MUL) state_d = S_MUL;
      S_MUL:   if (cnt_q == LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy     = (state_q == S_MUL);
    accept   = (state_q == S_IDLE) && start;
    mul_last = (state_q == S_MUL) && (cnt_q == LAST);
  end

  always_comb begin
    add_w   = {1'b0, A_in} + {1'b0, B_in};
    sub_w   = {1'b0, A_in} - {1'b0, B_in};
    alu_val = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (su)
      OP_ADD: begin
        alu_val = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (A_in[WIDTH-1] == B_in[WIDTH-1]) && (add_w[WIDTH-1] != A_in[WIDTH-1]);
      end
      OP_SUB: begin
        // The extra top bit of the widened difference is exactly the unsigned borrow.
        alu_val = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];
        alu_v   = (A_in[WIDTH-1] != B_in[WIDTH-1]) && (sub_w[WIDTH-1] != A_in[WIDTH-1]);
      end
      OP_AND: alu_val = A_in & B_in;
      OP_OR:  alu_val = A_in | B_in;
      OP_XOR: alu_val = A_in ^ B_in;
      OP_SHL: begin
        alu_val = {A_in[WIDTH-2:0], 1'b0};
        alu_c   = A_in[WIDTH-1];
      end
      OP_SHR: begin
        alu_val = {1'b0, A_in[WIDTH-1:1]};
        alu_c   = A_in[0];
      end
      default: alu_val = '0;
    endcase
  end

  // Shift-add step: b_q shifts right so bit 0 is always the current multiplier bit.
  always_comb begin
    partial   = b_q[0] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0;
    prod_next = prod_q + partial;
  end

  always_comb begin
    load_en  = 1'b0;
    load_val = result_q;
    load_c   = 1'b0;
    load_v   = 1'b0;
    if (accept && su != OP_MUL) begin
      load_en  = 1'b1;
      load_val = alu_val;
      load_c   = alu_c;
      load_v   = alu_v;
    end else if (mul_last) begin
      load_en  = 1'b1;
      load_val = prod_next[WIDTH-1:0];
      load_c   = |prod_next[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      if (accept) begin
        a_q    <= A_in;
        b_q    <= B_in;
        prod_q <= '0;
        cnt_q  <= '0;
      end else if (state_q == S_MUL) begin
        b_q    <= {1'b0, b_q[WIDTH-1:1]};
        prod_q <= prod_next;
        cnt_q  <= mul_last ? '0 : cnt_q + 1'b1;
      end
      if (load_en) begin
        result_q <= load_val;
        flags_q  <= {load_c, ~|load_val, load_val[WIDTH-1], load_v};
      end
      done_q <= load_en;
    end
  end

  assign done    = done_q;
  assign flags   = flags_q;
  assign ALU_Out = eu ? result_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized self-checking bench for alu_seq against an arithmetic model
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] A_in;
  logic [7:0] B_in;
  logic [2:0] su;
  logic       start;
  logic       eu;
  logic       busy;
  logic       done;
  logic [3:0] flags;
  wire  [7:0] bus;
  logic       tb_en;
  logic [7:0] tb_val;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [11:0] prev;

  assign bus = tb_en ? tb_val : 8'bz;

  alu_seq #(.WIDTH(8)) dut (
    .clk     (clk),
    .clr     (clr),
    .A_in    (A_in),
    .B_in    (B_in),
    .su      (su),
    .start   (start),
    .eu      (eu),
    .ALU_Out (bus),
    .busy    (busy),
    .done    (done),
    .flags   (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns {C,Z,N,V, result} computed with integer arithmetic.
  function automatic logic [11:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int ai, bi, sa, sb, r, ss, res, c, v;
    ai = a; bi = b;
    sa = (ai > 127) ? ai - 256 : ai;
    sb = (bi > 127) ? bi - 256 : bi;
    c = 0; v = 0; res = 0;
    case (op)
      3'd0: begin r = ai + bi; res = r % 256; c = (r > 255); ss = sa + sb; v = (ss > 127 || ss < -128); end
      3'd1: begin r = ai - bi; res = (r + 256) % 256; c = (ai < bi); ss = sa - sb; v = (ss > 127 || ss < -128); end
      3'd2: res = ai & bi;
      3'd3: res = ai | bi;
      3'd4: res = ai ^ bi;
      3'd5: begin res = (ai * 2) % 256; c = (ai >= 128); end
      3'd6: begin res = ai / 2; c = ai % 2; end
      default: begin r = ai * bi; res = r % 256; c = (r >= 256); end
    endcase
    return {c[0], (res == 0), (res >= 128), v[0], res[7:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input bit mid);
    logic [11:0] e;
    e = ref_op(op, a, b);
    A_in = a; B_in = b; su = op; start = 1'b1;
    step();
    start = 1'b0;
    if (op != 3'b111) begin
      chk("op_done", {15'd0, done}, 16'd1);
      chk("op_busy", {15'd0, busy}, 16'd0);
    end else begin
      for (int i = 1; i <= 8; i++) begin
        chk("mul_busy", {15'd0, busy}, 16'd1);
        chk("mul_nodone", {15'd0, done}, 16'd0);
        if (mid && i == 3) begin
          A_in = ~a; B_in = 8'h01; su = 3'b000; start = 1'b1;
          chk("mid_bus_prev", {8'd0, bus}, {8'd0, prev[7:0]});
          chk("mid_flags_prev", {12'd0, flags}, {12'd0, prev[11:8]});
          eu = 1'b0; tb_en = 1'b1; tb_val = 8'h3C;
          #1;
          chk("mid_bus_release", {8'd0, bus}, 16'h003C);
          tb_en = 1'b0; eu = 1'b1;
          #1;
        end
        step();
        start = 1'b0;
      end
      chk("mul_end_busy", {15'd0, busy}, 16'd0);
      chk("mul_end_done", {15'd0, done}, 16'd1);
    end
    chk("result", {8'd0, bus}, {8'd0, e[7:0]});
    chk("flags", {12'd0, flags}, {12'd0, e[11:8]});
    chk("busy_done_excl", {15'd0, busy & done}, 16'd0);
    prev = e;
  endtask

  initial begin
    clr = 1'b1; A_in = '0; B_in = '0; su = '0; start = 1'b0; eu = 1'b1;
    tb_en = 1'b0; tb_val = '0; prev = '0;
    start = 1'b1;
    step(); step();
    start = 1'b0;
    chk("rst_result", {8'd0, bus}, 16'd0);
    chk("rst_flags", {12'd0, flags}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    clr = 1'b0;
    step();
    chk("idle_after_rst_done", {15'd0, done}, 16'd0);

    do_op(3'b000, 8'hFF, 8'h01, 1'b0);
    chk("add_ff_01_flags", {12'd0, flags}, 16'b1100);
    step();
    chk("done_clears", {15'd0, done}, 16'd0);
    do_op(3'b001, 8'h05, 8'h07, 1'b0);
    chk("sub_05_07", {4'd0, flags, bus}, {4'd0, 4'b1010, 8'hFE});
    do_op(3'b000, 8'h7F, 8'h01, 1'b0);
    chk("add_7f_01", {4'd0, flags, bus}, {4'd0, 4'b0011, 8'h80});
    do_op(3'b100, 8'hAA, 8'hFF, 1'b0);
    chk("xor_aa_ff", {8'd0, bus}, 16'h0055);
    do_op(3'b101, 8'h81, 8'h00, 1'b0);
    chk("shl_81", {4'd0, flags[3], 3'd0, bus}, {4'd0, 4'b1000, 8'h02});
    do_op(3'b110, 8'h01, 8'h00, 1'b0);
    chk("shr_01", {4'd0, flags, bus}, {4'd0, 4'b1100, 8'h00});
    do_op(3'b111, 8'h0C, 8'h0B, 1'b1);
    chk("mul_0c_0b", {4'd0, flags[3], 3'd0, bus}, {4'd0, 4'b0000, 8'h84});
    do_op(3'b111, 8'h20, 8'h10, 1'b0);
    chk("mul_20_10", {4'd0, flags, bus}, {4'd0, 4'b1100, 8'h00});

    repeat (60) begin
      do_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) step();
    end

    // Abort a multiply with clr mid-cycle, four cycles in
    A_in = 8'h37; B_in = 8'h55; su = 3'b111; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    #2 clr = 1'b1;
    #1;
    chk("abort_result", {8'd0, bus}, 16'd0);
    chk("abort_flags", {12'd0, flags}, 16'd0);
    chk("abort_busy", {15'd0, busy}, 16'd0);
    chk("abort_done", {15'd0, done}, 16'd0);
    step();
    clr = 1'b0;
    prev = '0;
    step();
    chk("abort_no_done", {15'd0, done}, 16'd0);
    do_op(3'b000, 8'h01, 8'h02, 1'b0);
    chk("post_abort_add", {8'd0, bus}, 16'h0003);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered ALU for the SAP datapath, successor to the combinational 4-function ALU. It adds XOR, shifts and a multi-cycle unsigned multiply, and keeps a full WIDTH-bit result register and a separate carry, so the carry no longer overwrites the result MSB. Four status flags are registered for the future conditional-jump controller. A start/busy/done handshake connects it to the controller. The result drives the shared W-bus through a tri-state output gated by `eu`.

## Interface
- `WIDTH`, default 8: operand, result and bus width; legal range ≥ 2.
- `clk`  in  1  rising-edge clock.
- `clr`  in  1  asynchronous reset, active high.
- `A_in`  in  WIDTH  operand A (accumulator).
- `B_in`  in  WIDTH  operand B (B register).
- `su`  in  3  operation select, sampled with `start`.
- `start`  in  1  request; accepted only in IDLE.
- `eu`  in  1  bus enable; `ALU_Out` = result register when 1, all-Z when 0.
- `ALU_Out`  out  WIDTH  tri-state result.
- `busy`  out  1  high while a multiply is in progress.
- `done`  out  1  one-cycle pulse: result and flags just updated.
- `flags`  out  4  {C, Z, N, V}, registered.

## Operation
- `su` encoding:
  - 000 ADD: A+B; C = carry out.
  - 001 SUB: A−B (mod 2^WIDTH); C = borrow (A < B unsigned).
  - 010 AND; 011 OR; 100 XOR.
  - 101 SHL: A<<1; C = A[WIDTH−1].
  - 110 SHR (logical): A>>1; C = A[0].
  - 111 MUL: unsigned A×B; result = low WIDTH bits; C = 1 if the high WIDTH bits are nonzero.
- Flags:
  - Z = (result == 0).
  - N = result[WIDTH−1].
  - V = signed overflow for ADD/SUB only; 0 for every other op.
  - C = 0 for AND/OR/XOR.
- States:
  - IDLE: `start`=1 captures A, B and `su`. Non-MUL ops load the result register and flags at this same edge, set `done`, and stay in IDLE. MUL clears the 2·WIDTH-bit product and a bit counter, and goes to MUL.
  - MUL: one multiplier bit per cycle (shift-add), WIDTH iterations. On the last iteration, load result and flags, set `done`, return to IDLE.
- Operand behaviour: captured operands are used throughout the operation; changes on `A_in`/`B_in` during MUL have no effect.
- `start` in MUL is ignored; no queueing.
- The result register and flags hold their value until the next completed operation, including throughout MUL.
- `eu` is purely combinational on the output and independent of state; driving the bus mid-MUL shows the previous result.

## Timing
- Reset values: result register 0, `flags`=0000, `busy`=0, `done`=0, state IDLE, counter 0. `ALU_Out` = 0 if `eu`=1, otherwise Z.
- Reset mid-MUL aborts the multiply immediately; no `done` is produced.
- Non-MUL op:
  - `start` sampled at edge k → result, flags and `done`=1 visible after edge k.
  - `done` clears after edge k+1 unless a new op completes at that edge.
- MUL:
  - `start` at edge k → `busy`=1 after edge k.
  - Result and flags update at edge k+WIDTH; at that edge `busy`→0 and `done`→1.
- Back-to-back: `start` is accepted in the cycle where `done`=1, because the block is already in IDLE.
- `busy` and `done` are never both 1.
- `start` with `clr`=1 is ignored.

## Test plan
- Run all cases with WIDTH=8.
- ADD 0xFF+0x01 → result 0x00, flags C=1 Z=1 N=0 V=0; `done` one cycle after the start edge; `busy` stays 0.
- SUB 0x05−0x07 → 0xFE, C=1 N=1 Z=0 V=0. ADD 0x7F+0x01 → 0x80, V=1 N=1 C=0.
- XOR 0xAA^0xFF → 0x55. SHL 0x81 → 0x02, C=1. SHR 0x01 → 0x00, C=1 Z=1.
- MUL 0x0C×0x0B → `busy` for 8 cycles, then 0x84 with C=0 and `done` at edge k+8. MUL 0x20×0x10 → 0x00, C=1 Z=1.
- Mid-MUL checks:
  - Pulsing `start` with ADD is ignored.
  - `A_in` changes are ignored.
  - `ALU_Out` with `eu`=1 shows the previous result.
  - `eu`=0 gives all-Z.
- Assert `clr` at cycle 4 of a MUL → result, flags, `busy` and `done` are all 0 immediately; a new ADD 0x01+0x02 afterwards → 0x03.
